// File: rtl/banked_registerfile.sv
// Banked ARM-style register file: 16 architectural GPRs with mode-banked copies, a CPSR and one SPSR per exception mode.
// Optional macro RF_BYPASS_EN adds same-cycle write-to-read forwarding on the three read ports.
module banked_registerfile #(
  parameter int                 DBUSLEN  = 32,
  parameter int                 ADDRLEN  = 4,
  parameter logic [DBUSLEN-1:0] RESET_PC = '0
) (
  input  logic               sysclk,
  input  logic               sysrst_n,
  input  logic [ADDRLEN-1:0] RF_Addr_A,
  input  logic [ADDRLEN-1:0] RF_Addr_B,
  input  logic [ADDRLEN-1:0] RF_Addr_C,
  input  logic [ADDRLEN-1:0] RF_Addr_Write,
  input  logic [DBUSLEN-1:0] RF_Bus_Write,
  input  logic               RF_Load_Write,
  input  logic [DBUSLEN-1:0] RF_PC_Write,
  input  logic               RF_Load_PC,
  input  logic [31:0]        RF_Flags_Write,
  input  logic               RF_Load_Flags,
  input  logic               RF_PSR_R_Sel,
  input  logic               RF_PSR_W_Sel,
  input  logic               RF_Force_User,
  output logic [DBUSLEN-1:0] RF_Bus_A,
  output logic [DBUSLEN-1:0] RF_Bus_B,
  output logic [DBUSLEN-1:0] RF_Bus_C,
  output logic [DBUSLEN-1:0] RF_PC_Read,
  output logic [31:0]        RF_PSR_Read,
  output logic [4:0]         RF_Mode
);

  typedef enum logic [2:0] {
    BK_USR = 3'd0,
    BK_FIQ = 3'd1,
    BK_IRQ = 3'd2,
    BK_SVC = 3'd3,
    BK_ABT = 3'd4,
    BK_UND = 3'd5
  } bank_t;

  // Physical layout: user R0-R14 at 0..14, FIQ R8-R14 at 15..21, then R13/R14 pairs for IRQ, SVC, ABT, UND.
  localparam int NUM_PHYS  = 30;
  localparam int PHYS_W    = 5;
  localparam int NUM_BANKS = 6;
  localparam int FIQ_BASE  = 15;
  localparam int PAIR_BASE = 22;

  localparam logic [ADDRLEN-1:0] PC_ADDR    = ADDRLEN'(15);
  localparam logic [31:0]        CPSR_RESET = 32'h0000_00D3;

  logic [DBUSLEN-1:0] gpr [NUM_PHYS];
  logic [DBUSLEN-1:0] pc;
  logic [DBUSLEN-1:0] pc_next;
  logic [31:0]        cpsr;
  logic [31:0]        spsr [NUM_BANKS];

  bank_t              mode_bank;
  bank_t              gpr_bank;
  logic               has_spsr;
  logic               write_gpr;
  logic               write_pc;
  logic [PHYS_W-1:0]  write_idx;

  logic [ADDRLEN-1:0] rd_addr [3];
  logic [DBUSLEN-1:0] rd_data [3];

  function automatic bank_t decode_mode(input logic [4:0] mode);
    bank_t bank;
    case (mode)
      5'h11:   bank = BK_FIQ;
      5'h12:   bank = BK_IRQ;
      5'h13:   bank = BK_SVC;
      5'h17:   bank = BK_ABT;
      5'h1B:   bank = BK_UND;
      default: bank = BK_USR;
    endcase
    return bank;
  endfunction

  // Address 15 is never looked up here; the PC lives in its own register.
  function automatic logic [PHYS_W-1:0] phys_index(input bank_t bank, input logic [ADDRLEN-1:0] addr);
    int a;
    int idx;
    a   = int'(addr);
    idx = a;
    case (bank)
      BK_FIQ: begin
        if (a >= 8 && a <= 14) idx = FIQ_BASE + a - 8;
      end
      BK_IRQ, BK_SVC, BK_ABT, BK_UND: begin
        if (a >= 13 && a <= 14) idx = PAIR_BASE + 2 * (int'(bank) - int'(BK_IRQ)) + a - 13;
      end
      default: ;
    endcase
    return PHYS_W'(idx);
  endfunction

  // NOTE: every signal driven here gets a default before any condition, so no latch can be inferred.
  always_comb begin
    mode_bank = decode_mode(cpsr[4:0]);
    gpr_bank  = RF_Force_User ? BK_USR : mode_bank;
    has_spsr  = (mode_bank != BK_USR);
    write_gpr = RF_Load_Write && (RF_Addr_Write != PC_ADDR);
    write_pc  = RF_Load_Write && (RF_Addr_Write == PC_ADDR);
    write_idx = phys_index(gpr_bank, RF_Addr_Write);
    pc_next   = pc;
    if (write_pc) begin
      pc_next = RF_Bus_Write;
    end else if (RF_Load_PC) begin
      pc_next = RF_PC_Write;
    end
  end

  assign rd_addr[0] = RF_Addr_A;
  assign rd_addr[1] = RF_Addr_B;
  assign rd_addr[2] = RF_Addr_C;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      if (rd_addr[p] == PC_ADDR) begin
        rd_data[p] = pc;
      end else begin
        rd_data[p] = gpr[phys_index(gpr_bank, rd_addr[p])];
      end
`ifdef RF_BYPASS_EN
      // Read and write resolve through the same bank, so raw address equality is resolved-address equality.
      // For address 15 the general write always wins the next-PC race, so RF_Bus_Write is the forwarded PC.
      if (RF_Load_Write && (rd_addr[p] == RF_Addr_Write)) begin
        rd_data[p] = RF_Bus_Write;
      end
`endif
    end
  end

  assign RF_Bus_A    = rd_data[0];
  assign RF_Bus_B    = rd_data[1];
  assign RF_Bus_C    = rd_data[2];
  assign RF_PC_Read  = pc;
  assign RF_PSR_Read = (RF_PSR_R_Sel && has_spsr) ? spsr[mode_bank] : cpsr;
  assign RF_Mode     = cpsr[4:0];

  // NOTE: state updates use non-blocking assignments so a GPR write and a CPSR write in the same
  // cycle both see the pre-edge mode; the new bank only becomes visible after the edge.
  always_ff @(posedge sysclk) begin
    if (!sysrst_n) begin
      // NOTE: the whole array is cleared because every banked copy must read zero after reset;
      // this deliberately keeps the storage as flops rather than a RAM macro.
      for (int i = 0; i < NUM_PHYS; i++) begin
        gpr[i] <= '0;
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
        spsr[b] <= '0;
      end
      pc   <= RESET_PC;
      cpsr <= CPSR_RESET;
    end else begin
      if (write_gpr) begin
        gpr[write_idx] <= RF_Bus_Write;
      end
      pc <= pc_next;
      if (RF_Load_Flags) begin
        if (!RF_PSR_W_Sel) begin
          cpsr <= RF_Flags_Write;
        end else if (has_spsr) begin
          spsr[mode_bank] <= RF_Flags_Write;
        end
      end
    end
  end

endmodule

// File: tb/tb_banked_registerfile.sv
// Self-checking bench for banked_registerfile: directed sequences, a table of banking vectors,
// and randomized traffic against a mode-ownership reference model.
module tb_banked_registerfile;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          N_RAND   = 3000;

  logic        sysclk = 1'b0;
  logic        sysrst_n;
  logic [3:0]  RF_Addr_A, RF_Addr_B, RF_Addr_C, RF_Addr_Write;
  logic [31:0] RF_Bus_Write, RF_PC_Write, RF_Flags_Write;
  logic        RF_Load_Write, RF_Load_PC, RF_Load_Flags;
  logic        RF_PSR_R_Sel, RF_PSR_W_Sel, RF_Force_User;
  logic [31:0] RF_Bus_A, RF_Bus_B, RF_Bus_C, RF_PC_Read, RF_PSR_Read;
  logic [4:0]  RF_Mode;

  int n_vec  = 0;
  int n_miss = 0;

  banked_registerfile #(
    .DBUSLEN (32),
    .ADDRLEN (4),
    .RESET_PC(RESET_PC)
  ) dut (
    .sysclk        (sysclk),
    .sysrst_n      (sysrst_n),
    .RF_Addr_A     (RF_Addr_A),
    .RF_Addr_B     (RF_Addr_B),
    .RF_Addr_C     (RF_Addr_C),
    .RF_Addr_Write (RF_Addr_Write),
    .RF_Bus_Write  (RF_Bus_Write),
    .RF_Load_Write (RF_Load_Write),
    .RF_PC_Write   (RF_PC_Write),
    .RF_Load_PC    (RF_Load_PC),
    .RF_Flags_Write(RF_Flags_Write),
    .RF_Load_Flags (RF_Load_Flags),
    .RF_PSR_R_Sel  (RF_PSR_R_Sel),
    .RF_PSR_W_Sel  (RF_PSR_W_Sel),
    .RF_Force_User (RF_Force_User),
    .RF_Bus_A      (RF_Bus_A),
    .RF_Bus_B      (RF_Bus_B),
    .RF_Bus_C      (RF_Bus_C),
    .RF_PC_Read    (RF_PC_Read),
    .RF_PSR_Read   (RF_PSR_Read),
    .RF_Mode       (RF_Mode)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [31:0] m_gpr  [int];
  logic [31:0] m_spsr [int];
  logic [31:0] m_pc;
  logic [31:0] m_cpsr;

  function automatic bit is_exc(input logic [4:0] mode);
    return mode inside {5'h11, 5'h12, 5'h13, 5'h17, 5'h1B};
  endfunction

  // Which mode's copy of a register is addressed: FIQ owns R8-R14, other exception modes own R13-R14.
  function automatic int owner(input logic [4:0] mode, input logic force_u, input logic [3:0] addr);
    if (force_u || !is_exc(mode)) return 'h10;
    if (mode == 5'h11 && addr >= 4'd8) return 'h11;
    if (addr >= 4'd13) return int'(mode);
    return 'h10;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] addr);
    int key;
`ifdef RF_BYPASS_EN
    if (RF_Load_Write && addr == RF_Addr_Write) return RF_Bus_Write;
`endif
    if (addr == 4'd15) return m_pc;
    key = owner(m_cpsr[4:0], RF_Force_User, addr) * 16 + int'(addr);
    return m_gpr.exists(key) ? m_gpr[key] : 32'h0;
  endfunction

  function automatic logic [31:0] m_psr_read();
    int mode;
    mode = int'(m_cpsr[4:0]);
    if (RF_PSR_R_Sel && is_exc(m_cpsr[4:0])) return m_spsr.exists(mode) ? m_spsr[mode] : 32'h0;
    return m_cpsr;
  endfunction

  task automatic m_update();
    logic [31:0] nxt_pc;
    int key;
    nxt_pc = m_pc;
    if (RF_Load_PC) nxt_pc = RF_PC_Write;
    if (RF_Load_Write && RF_Addr_Write == 4'd15) nxt_pc = RF_Bus_Write;
    if (RF_Load_Write && RF_Addr_Write != 4'd15) begin
      key = owner(m_cpsr[4:0], RF_Force_User, RF_Addr_Write) * 16 + int'(RF_Addr_Write);
      m_gpr[key] = RF_Bus_Write;
    end
    if (RF_Load_Flags) begin
      if (!RF_PSR_W_Sel) m_cpsr = RF_Flags_Write;
      else if (is_exc(m_cpsr[4:0])) m_spsr[int'(m_cpsr[4:0])] = RF_Flags_Write;
    end
    m_pc = nxt_pc;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic clear_inputs();
    RF_Addr_A = 4'd0; RF_Addr_B = 4'd0; RF_Addr_C = 4'd0; RF_Addr_Write = 4'd0;
    RF_Bus_Write = 32'h0; RF_PC_Write = 32'h0; RF_Flags_Write = 32'h0;
    RF_Load_Write = 1'b0; RF_Load_PC = 1'b0; RF_Load_Flags = 1'b0;
    RF_PSR_R_Sel = 1'b0; RF_PSR_W_Sel = 1'b0; RF_Force_User = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    sysrst_n = 1'b0;
    tick();
    tick();
    sysrst_n = 1'b1;
    #1;
  endtask

  task automatic psr_write(input logic sel, input logic [31:0] val);
    RF_PSR_W_Sel = sel; RF_Flags_Write = val; RF_Load_Flags = 1'b1;
    tick();
    RF_Load_Flags = 1'b0; RF_PSR_W_Sel = 1'b0;
  endtask

  task automatic set_mode(input logic [4:0] m);
    psr_write(1'b0, {24'h0, 3'b110, m});
  endtask

  task automatic gpr_write(input logic [3:0] addr, input logic [31:0] data, input logic force_u);
    RF_Addr_Write = addr; RF_Bus_Write = data; RF_Force_User = force_u; RF_Load_Write = 1'b1;
    tick();
    RF_Load_Write = 1'b0; RF_Force_User = 1'b0;
  endtask

  task automatic check_read(input string name, input logic [3:0] addr, input logic force_u,
                            input logic [31:0] exp);
    RF_Addr_A = addr; RF_Force_User = force_u;
    #1;
    check(name, RF_Bus_A, exp);
    RF_Force_User = 1'b0;
  endtask

  // ---------------- banking vector table ----------------
  typedef struct {
    logic [4:0]  wmode;
    logic        wen;
    logic        wforce;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  rmode;
    logic        rforce;
    logic [3:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  logic [4:0] modes [8];

  initial begin
    logic [31:0] tmp;

    tbl[0]  = '{5'h10, 1'b1, 1'b0, 4'd0,  32'h11, 5'h11, 1'b0, 4'd0,  32'h11};
    tbl[1]  = '{5'h11, 1'b1, 1'b0, 4'd9,  32'h22, 5'h10, 1'b0, 4'd9,  32'h00};
    tbl[2]  = '{5'h10, 1'b1, 1'b0, 4'd9,  32'h33, 5'h11, 1'b1, 4'd9,  32'h33};
    tbl[3]  = '{5'h12, 1'b1, 1'b0, 4'd14, 32'h44, 5'h13, 1'b0, 4'd14, 32'h00};
    tbl[4]  = '{5'h17, 1'b1, 1'b0, 4'd13, 32'h55, 5'h17, 1'b0, 4'd13, 32'h55};
    tbl[5]  = '{5'h1B, 1'b1, 1'b0, 4'd13, 32'h66, 5'h17, 1'b0, 4'd13, 32'h55};
    tbl[6]  = '{5'h1F, 1'b1, 1'b0, 4'd13, 32'h77, 5'h10, 1'b0, 4'd13, 32'h77};
    tbl[7]  = '{5'h15, 1'b1, 1'b0, 4'd14, 32'h88, 5'h10, 1'b0, 4'd14, 32'h88};
    tbl[8]  = '{5'h13, 1'b1, 1'b1, 4'd14, 32'h99, 5'h1F, 1'b0, 4'd14, 32'h99};
    tbl[9]  = '{5'h13, 1'b0, 1'b0, 4'd0,  32'h00, 5'h13, 1'b0, 4'd14, 32'h00};
    tbl[10] = '{5'h11, 1'b1, 1'b0, 4'd12, 32'hAA, 5'h12, 1'b0, 4'd12, 32'h00};
    tbl[11] = '{5'h11, 1'b0, 1'b0, 4'd0,  32'h00, 5'h11, 1'b0, 4'd9,  32'h22};

    modes = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F, 5'h15};

    // Reset state
    do_reset();
    RF_Addr_A = 4'd0; RF_Addr_B = 4'd15; RF_Addr_C = 4'd13;
    #1;
    check("rst_bus_a", RF_Bus_A, 32'h0);
    check("rst_bus_b", RF_Bus_B, RESET_PC);
    check("rst_bus_c", RF_Bus_C, 32'h0);
    check("rst_pc", RF_PC_Read, RESET_PC);
    check("rst_cpsr", RF_PSR_Read, 32'hD3);
    check("rst_mode", 32'(RF_Mode), 32'h13);
    RF_PSR_R_Sel = 1'b1;
    #1;
    check("rst_spsr", RF_PSR_Read, 32'h0);
    RF_PSR_R_Sel = 1'b0;

    // Write order across SVC and USR banks of R13
    gpr_write(4'd13, 32'h0000_00FF, 1'b0);
    psr_write(1'b0, 32'h10);
    check("usr_mode", 32'(RF_Mode), 32'h10);
    gpr_write(4'd13, 32'h0000_FFFF, 1'b0);
    check_read("usr_r13", 4'd13, 1'b0, 32'h0000_FFFF);
    psr_write(1'b0, 32'hD3);
    check_read("svc_r13", 4'd13, 1'b0, 32'h0000_00FF);

    // FIQ banking of R8
    psr_write(1'b0, 32'h10);
    gpr_write(4'd8, 32'h0000_0FFF, 1'b0);
    psr_write(1'b0, 32'hD1);
    gpr_write(4'd8, 32'h20, 1'b0);
    check_read("fiq_r8", 4'd8, 1'b0, 32'h20);
    check_read("fiq_r8_force_user", 4'd8, 1'b1, 32'h0000_0FFF);

    // PC write priority
    RF_Load_PC = 1'b1; RF_PC_Write = 32'h4;
    RF_Load_Write = 1'b1; RF_Addr_Write = 4'd15; RF_Bus_Write = 32'h10;
    tick();
    RF_Load_Write = 1'b0;
    RF_Addr_A = 4'd15;
    #1;
    check("pc_write_priority", RF_PC_Read, 32'h10);
    check("pc_via_bus_a", RF_Bus_A, 32'h10);
    RF_PC_Write = 32'h8;
    tick();
    RF_Load_PC = 1'b0;
    check("pc_load_only", RF_PC_Read, 32'h8);

    // SPSR handling
    psr_write(1'b0, 32'h92);
    psr_write(1'b1, 32'hF000_0010);
    RF_PSR_R_Sel = 1'b1;
    #1;
    check("irq_spsr", RF_PSR_Read, 32'hF000_0010);
    check("irq_cpsr_kept", 32'(RF_Mode), 32'h12);
    psr_write(1'b0, 32'h10);
    psr_write(1'b1, 32'h1);
    #1;
    check("usr_spsr_reads_cpsr", RF_PSR_Read, 32'h10);
    psr_write(1'b0, 32'h92);
    #1;
    check("irq_spsr_untouched", RF_PSR_Read, 32'hF000_0010);
    RF_PSR_R_Sel = 1'b0;

    // Same-cycle write and read of R3
    RF_Addr_A = 4'd3; RF_Addr_Write = 4'd3; RF_Bus_Write = 32'h55AA; RF_Load_Write = 1'b1;
    #1;
`ifdef RF_BYPASS_EN
    check("bypass_pre_edge", RF_Bus_A, 32'h55AA);
`else
    check("no_bypass_pre_edge", RF_Bus_A, 32'h0);
`endif
    tick();
    RF_Load_Write = 1'b0;
    #1;
    check("post_edge_r3", RF_Bus_A, 32'h55AA);

    // Mode change and GPR write in the same cycle: write lands in the old (IRQ) bank
    RF_Load_Flags = 1'b1; RF_PSR_W_Sel = 1'b0; RF_Flags_Write = 32'h10;
    RF_Load_Write = 1'b1; RF_Addr_Write = 4'd13; RF_Bus_Write = 32'hABC;
    tick();
    RF_Load_Flags = 1'b0; RF_Load_Write = 1'b0;
    check_read("mode_switch_usr_r13", 4'd13, 1'b0, 32'h0000_FFFF);
    psr_write(1'b0, 32'h92);
    check_read("mode_switch_irq_r13", 4'd13, 1'b0, 32'hABC);

    // Reset wins over every load enable
    RF_Load_Write = 1'b1; RF_Addr_Write = 4'd3; RF_Bus_Write = 32'h1234;
    RF_Load_PC = 1'b1; RF_PC_Write = 32'h44;
    RF_Load_Flags = 1'b1; RF_Flags_Write = 32'h1F;
    sysrst_n = 1'b0;
    tick();
    sysrst_n = 1'b1;
    clear_inputs();
    #1;
    check_read("rst_prio_r3", 4'd3, 1'b0, 32'h0);
    check("rst_prio_pc", RF_PC_Read, RESET_PC);
    check("rst_prio_mode", 32'(RF_Mode), 32'h13);

    // Banking table, starting from the reset state above
    for (int i = 0; i < 12; i++) begin
      set_mode(tbl[i].wmode);
      if (tbl[i].wen) gpr_write(tbl[i].waddr, tbl[i].wdata, tbl[i].wforce);
      set_mode(tbl[i].rmode);
      check_read($sformatf("tbl%0d", i), tbl[i].raddr, tbl[i].rforce, tbl[i].exp);
    end

    // Randomized traffic against the reference model
    do_reset();
    m_gpr.delete();
    m_spsr.delete();
    m_pc   = RESET_PC;
    m_cpsr = 32'hD3;
    for (int n = 0; n < N_RAND; n++) begin
      RF_Addr_A     = 4'($urandom_range(0, 15));
      RF_Addr_B     = 4'($urandom_range(0, 15));
      RF_Addr_C     = 4'($urandom_range(0, 15));
      RF_Addr_Write = 4'($urandom_range(0, 15));
      RF_Bus_Write  = $urandom;
      RF_Load_Write = ($urandom_range(0, 2) == 0);
      RF_PC_Write   = $urandom;
      RF_Load_PC    = ($urandom_range(0, 3) == 0);
      RF_Load_Flags = ($urandom_range(0, 4) == 0);
      RF_PSR_W_Sel  = 1'($urandom_range(0, 1));
      RF_PSR_R_Sel  = 1'($urandom_range(0, 1));
      RF_Force_User = ($urandom_range(0, 3) == 0);
      tmp = $urandom;
      RF_Flags_Write = RF_PSR_W_Sel ? tmp : {tmp[31:5], modes[$urandom_range(0, 7)]};
      #1;
      check("rand_bus_a", RF_Bus_A, m_read(RF_Addr_A));
      check("rand_bus_b", RF_Bus_B, m_read(RF_Addr_B));
      check("rand_bus_c", RF_Bus_C, m_read(RF_Addr_C));
      check("rand_pc", RF_PC_Read, m_pc);
      check("rand_psr", RF_PSR_Read, m_psr_read());
      check("rand_mode", 32'(RF_Mode), 32'(m_cpsr[4:0]));
      m_update();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
